// File: rtl/branch_redirect_ctrl_pkg.sv
// Shared types and constants for the MEM-stage branch redirect controller.
package branch_redirect_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REDIRECT = 2'd1,
    ST_DRAIN    = 2'd2
  } state_e;

  localparam int ADDR_W_DEF = 64;
  localparam int CNT_W_DEF  = 32;
  localparam int DRAIN_W    = 3;   // holds DRAIN_CYC up to 7

  function automatic logic br_take(input logic v, input logic b, input logic u, input logic z);
    return v & ((b & z) | u);
  endfunction

  function automatic logic br_resolve(input logic v, input logic b, input logic u);
    return v & (b | u);
  endfunction

endpackage

// File: rtl/branch_redirect_ctrl_if.sv
// MEM-stage branch inputs and redirect/flush/statistics outputs.
interface branch_redirect_ctrl_if
  import branch_redirect_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
);
  logic              mem_valid;
  logic              mem_branch;
  logic              mem_uncond;
  logic              mem_zero;
  logic [ADDR_W-1:0] mem_target;
  logic              stall;
  logic              pc_src;
  logic [ADDR_W-1:0] pc_target;
  logic              flush_ifid;
  logic              flush_idex;
  logic              flush_exmem;
  logic              busy;
  logic [CNT_W-1:0]  branch_count;
  logic [CNT_W-1:0]  taken_count;

  modport master (
    output mem_valid, mem_branch, mem_uncond, mem_zero, mem_target, stall,
    input  pc_src, pc_target, flush_ifid, flush_idex, flush_exmem, busy,
           branch_count, taken_count
  );

  modport slave (
    input  mem_valid, mem_branch, mem_uncond, mem_zero, mem_target, stall,
    output pc_src, pc_target, flush_ifid, flush_idex, flush_exmem, busy,
           branch_count, taken_count
  );
endinterface

// File: rtl/branch_redirect_ctrl_event_counter.sv
// Free-running wrap counter; increments on enable, wraps modulo 2^CNT_W.
module event_counter #(
  parameter int CNT_W = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_count
);
  logic [CNT_W-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_reset)   r_count <= '0;
    else if (i_en) r_count <= r_count + 1'b1;
  end

  assign o_count = r_count;
endmodule

// File: rtl/branch_redirect_ctrl.sv
// MEM-stage branch resolution: registered PC redirect, pipeline squash, drain window, stats.
module branch_redirect_ctrl
  import branch_redirect_ctrl_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DRAIN_CYC = 2,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  branch_redirect_ctrl_if.slave bus
);
  state_e              r_state;
  logic [DRAIN_W-1:0]  r_drain;
  logic                r_pc_src;
  logic                r_flush;
  logic                r_busy;
  logic [ADDR_W-1:0]   r_pc_target;

  logic w_take, w_resolve, w_eval;

  assign w_take    = br_take(bus.mem_valid, bus.mem_branch, bus.mem_uncond, bus.mem_zero);
  assign w_resolve = br_resolve(bus.mem_valid, bus.mem_branch, bus.mem_uncond);
  // Branches count only when the FSM actually evaluates them (idle, not stalled).
  assign w_eval    = (r_state == ST_IDLE) & ~bus.stall;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= ST_IDLE;
      r_drain     <= '0;
      r_pc_src    <= 1'b0;
      r_flush     <= 1'b0;
      r_busy      <= 1'b0;
      r_pc_target <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_eval && w_take) begin
            r_pc_target <= bus.mem_target;
            r_state     <= ST_REDIRECT;
            r_pc_src    <= 1'b1;
            r_flush     <= 1'b1;
            r_busy      <= 1'b1;
          end
        end
        ST_REDIRECT: begin
          // Stalled redirect holds until the pipeline can accept it.
          if (!bus.stall) begin
            r_drain  <= DRAIN_W'(DRAIN_CYC);
            r_state  <= ST_DRAIN;
            r_pc_src <= 1'b0;
            r_flush  <= 1'b0;
          end
        end
        ST_DRAIN: begin
          if (!bus.stall) begin
            r_drain <= r_drain - 1'b1;
            if (r_drain == DRAIN_W'(1)) begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end
          end
        end
        default: begin
          r_state  <= ST_IDLE;
          r_pc_src <= 1'b0;
          r_flush  <= 1'b0;
          r_busy   <= 1'b0;
        end
      endcase
    end
  end

  event_counter #(.CNT_W(CNT_W)) u_branch_cnt (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_en    (w_eval & w_resolve),
    .o_count (bus.branch_count)
  );

  event_counter #(.CNT_W(CNT_W)) u_taken_cnt (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_en    (w_eval & w_take),
    .o_count (bus.taken_count)
  );

  assign bus.pc_src      = r_pc_src;
  assign bus.pc_target   = r_pc_target;
  assign bus.flush_ifid  = r_flush;
  assign bus.flush_idex  = r_flush;
  assign bus.flush_exmem = r_flush;
  assign bus.busy        = r_busy;
endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Vector table, hand sequences and random stimulus against a cycle-level reference model.
module tb_branch_redirect_ctrl;
  localparam int DRAIN = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  branch_redirect_ctrl_if #(.ADDR_W(64), .CNT_W(32)) bus  ();
  branch_redirect_ctrl_if #(.ADDR_W(64), .CNT_W(4))  bus4 ();

  branch_redirect_ctrl #(.ADDR_W(64), .DRAIN_CYC(DRAIN), .CNT_W(32)) dut (
    .i_clk(clk), .i_reset(rst), .bus(bus));
  branch_redirect_ctrl #(.ADDR_W(64), .DRAIN_CYC(DRAIN), .CNT_W(4)) dut4 (
    .i_clk(clk), .i_reset(rst), .bus(bus4));

  // Narrow-counter instance sees the same stimulus.
  assign bus4.mem_valid  = bus.mem_valid;
  assign bus4.mem_branch = bus.mem_branch;
  assign bus4.mem_uncond = bus.mem_uncond;
  assign bus4.mem_zero   = bus.mem_zero;
  assign bus4.mem_target = bus.mem_target;
  assign bus4.stall      = bus.stall;

  // Reference: redirect pending flag plus remaining unstalled quiet cycles.
  bit          m_redir;
  int          m_quiet;
  logic [63:0] m_tgt;
  int unsigned m_bc, m_tc;

  task automatic model_edge();
    bit take, res;
    take = bus.mem_valid && ((bus.mem_branch && bus.mem_zero) || bus.mem_uncond);
    res  = bus.mem_valid && (bus.mem_branch || bus.mem_uncond);
    if (rst) begin
      m_redir = 0; m_quiet = 0; m_tgt = '0; m_bc = 0; m_tc = 0;
    end else if (m_redir) begin
      if (!bus.stall) begin m_redir = 0; m_quiet = DRAIN; end
    end else if (m_quiet > 0) begin
      if (!bus.stall) m_quiet--;
    end else if (!bus.stall) begin
      if (res) m_bc++;
      if (take) begin m_tc++; m_redir = 1; m_tgt = bus.mem_target; end
    end
  endtask

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic chk_all(string tag, logic src, logic fl, logic busy, logic [63:0] tgt,
                         int unsigned bc, int unsigned tc);
    chk({tag, " pc_src"}, 64'(bus.pc_src), 64'(src));
    chk({tag, " flush"}, 64'({bus.flush_ifid, bus.flush_idex, bus.flush_exmem}), 64'({3{fl}}));
    chk({tag, " busy"}, 64'(bus.busy), 64'(busy));
    chk({tag, " pc_target"}, bus.pc_target, tgt);
    chk({tag, " branch_count"}, 64'(bus.branch_count), 64'(bc));
    chk({tag, " taken_count"}, 64'(bus.taken_count), 64'(tc));
  endtask

  task automatic step(logic r, logic v, logic b, logic u, logic z, logic s, logic [63:0] t);
    rst = r;
    bus.mem_valid = v; bus.mem_branch = b; bus.mem_uncond = u;
    bus.mem_zero = z; bus.stall = s; bus.mem_target = t;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic chk_model(string tag);
    chk_all(tag, m_redir, m_redir, m_redir || (m_quiet > 0), m_tgt, m_bc, m_tc);
    chk({tag, " cnt4 branch"}, 64'(bus4.branch_count), 64'(m_bc[3:0]));
    chk({tag, " cnt4 taken"}, 64'(bus4.taken_count), 64'(m_tc[3:0]));
  endtask

  typedef struct {
    logic r, v, b, u, z, s;
    logic [63:0] t;
    logic e_src, e_busy;
    logic [63:0] e_tgt;
    int unsigned e_bc, e_tc;
  } vec_t;

  function automatic vec_t mk(logic r, logic v, logic b, logic u, logic z, logic s,
                              logic [63:0] t, logic e_src, logic e_busy,
                              logic [63:0] e_tgt, int unsigned e_bc, int unsigned e_tc);
    vec_t x;
    x.r = r; x.v = v; x.b = b; x.u = u; x.z = z; x.s = s; x.t = t;
    x.e_src = e_src; x.e_busy = e_busy; x.e_tgt = e_tgt; x.e_bc = e_bc; x.e_tc = e_tc;
    return x;
  endfunction

  vec_t vt[$];

  initial begin
    bus.mem_valid = 0; bus.mem_branch = 0; bus.mem_uncond = 0;
    bus.mem_zero = 0; bus.stall = 0; bus.mem_target = '0;

    //          r  v  b  u  z  s  target     src busy tgt        bc tc
    vt.push_back(mk(1, 0, 0, 0, 0, 0, 64'h0,     0, 0, 64'h0,    0, 0)); // reset
    vt.push_back(mk(0, 1, 0, 1, 0, 0, 64'h400,   1, 1, 64'h400,  1, 1)); // B taken
    vt.push_back(mk(0, 0, 0, 0, 0, 0, 64'h0,     0, 1, 64'h400,  1, 1));
    vt.push_back(mk(0, 0, 0, 0, 0, 0, 64'h0,     0, 1, 64'h400,  1, 1));
    vt.push_back(mk(0, 0, 0, 0, 0, 0, 64'h0,     0, 0, 64'h400,  1, 1));
    vt.push_back(mk(0, 1, 1, 0, 0, 0, 64'h999,   0, 0, 64'h400,  2, 1)); // CBZ not taken
    vt.push_back(mk(0, 1, 1, 0, 1, 0, 64'h800,   1, 1, 64'h800,  3, 2)); // CBZ taken
    vt.push_back(mk(0, 1, 0, 1, 0, 1, 64'hAAA,   1, 1, 64'h800,  3, 2)); // stalled redirect
    vt.push_back(mk(0, 1, 0, 1, 0, 1, 64'hAAA,   1, 1, 64'h800,  3, 2));
    vt.push_back(mk(0, 1, 0, 1, 0, 1, 64'hAAA,   1, 1, 64'h800,  3, 2));
    vt.push_back(mk(0, 0, 0, 0, 0, 0, 64'h0,     0, 1, 64'h800,  3, 2));
    vt.push_back(mk(0, 0, 0, 0, 0, 1, 64'h0,     0, 1, 64'h800,  3, 2)); // stall in drain
    vt.push_back(mk(0, 0, 0, 0, 0, 0, 64'h0,     0, 1, 64'h800,  3, 2));
    vt.push_back(mk(0, 1, 0, 1, 0, 0, 64'hBBB,   0, 0, 64'h800,  3, 2)); // ignored in drain
    vt.push_back(mk(0, 1, 0, 1, 0, 0, 64'hC00,   1, 1, 64'hC00,  4, 3));
    vt.push_back(mk(1, 1, 0, 1, 0, 0, 64'hD00,   0, 0, 64'h0,    0, 0)); // reset mid-redirect
    vt.push_back(mk(0, 1, 0, 1, 0, 0, 64'h500,   1, 1, 64'h500,  1, 1));
    vt.push_back(mk(0, 0, 0, 0, 0, 0, 64'h0,     0, 1, 64'h500,  1, 1));
    vt.push_back(mk(0, 0, 0, 0, 0, 0, 64'h0,     0, 1, 64'h500,  1, 1));
    vt.push_back(mk(0, 0, 0, 0, 0, 0, 64'h0,     0, 0, 64'h500,  1, 1));
    vt.push_back(mk(0, 1, 1, 1, 0, 0, 64'h600,   1, 1, 64'h600,  2, 2)); // both flags: once
    vt.push_back(mk(0, 0, 0, 0, 0, 0, 64'h0,     0, 1, 64'h600,  2, 2));
    vt.push_back(mk(0, 1, 0, 0, 0, 0, 64'h0,     0, 1, 64'h600,  2, 2));
    vt.push_back(mk(0, 0, 0, 0, 0, 0, 64'h0,     0, 0, 64'h600,  2, 2));
    vt.push_back(mk(0, 1, 0, 1, 0, 1, 64'h700,   0, 0, 64'h600,  2, 2)); // stalled in IDLE
    vt.push_back(mk(0, 1, 0, 1, 0, 0, 64'h700,   1, 1, 64'h700,  3, 3));
    vt.push_back(mk(0, 0, 0, 0, 0, 0, 64'h0,     0, 1, 64'h700,  3, 3));
    vt.push_back(mk(0, 0, 0, 0, 0, 0, 64'h0,     0, 1, 64'h700,  3, 3));
    vt.push_back(mk(0, 0, 0, 0, 0, 0, 64'h0,     0, 0, 64'h700,  3, 3));
    vt.push_back(mk(0, 0, 0, 1, 0, 0, 64'h900,   0, 0, 64'h700,  3, 3)); // invalid slot

    foreach (vt[i]) begin
      step(vt[i].r, vt[i].v, vt[i].b, vt[i].u, vt[i].z, vt[i].s, vt[i].t);
      chk_all($sformatf("vec%0d", i), vt[i].e_src, vt[i].e_src, vt[i].e_busy,
              vt[i].e_tgt, vt[i].e_bc, vt[i].e_tc);
    end

    // Back-to-back takes: redirects every 2+DRAIN cycles with the then-current target.
    step(1, 0, 0, 0, 0, 0, 64'h0);
    for (int i = 0; i < 10; i++) begin
      step(0, 1, 0, 1, 0, 0, 64'h100 + 64'(4 * i));
      chk($sformatf("b2b%0d pc_src", i), 64'(bus.pc_src), 64'((i % (2 + DRAIN)) == 0));
      if ((i % (2 + DRAIN)) == 0)
        chk($sformatf("b2b%0d pc_target", i), bus.pc_target, 64'h100 + 64'(4 * i));
    end

    // Counter wrap on the 4-bit build: 15 takes then one more.
    step(1, 0, 0, 0, 0, 0, 64'h0);
    for (int i = 0; i < 16; i++) begin
      step(0, 1, 0, 1, 0, 0, 64'h40 * 64'(i));
      for (int k = 0; k < 1 + DRAIN; k++) step(0, 0, 0, 0, 0, 0, 64'h0);
      if (i == 14) begin
        chk("wrap pre taken", 64'(bus4.taken_count), 64'd15);
        chk("wrap pre branch", 64'(bus4.branch_count), 64'd15);
      end
    end
    chk("wrap taken", 64'(bus4.taken_count), 64'd0);
    chk("wrap branch", 64'(bus4.branch_count), 64'd0);
    chk("wrap wide taken", 64'(bus.taken_count), 64'd16);

    // Random stimulus against the model.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 59) == 0), ($urandom_range(0, 3) != 0), 1'($urandom),
           ($urandom_range(0, 2) == 0), 1'($urandom), ($urandom_range(0, 3) == 0),
           {$urandom, $urandom});
      chk_model($sformatf("rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
